mem_port_arbiter: RTL

//  Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, data requester and memory-side signals of the
//   shared memory port.
//   slave  : arbiter view (serves the requesters and drives the memory).
//   master : environment view (pipeline requesters plus the memory model).
//   Fetch   : if_req, if_addr -> if_done, if_rdata
//   Data    : d_req, d_we, d_addr, d_wdata -> d_done, d_rdata
//   Memory  : mem_req, mem_we, mem_addr, mem_wdata <- mem_ack, mem_rdata
//   Status  : err, owner, busy
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    logic          err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          owner;
    logic          busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata, owner, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata, owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between instruction
//   fetch (IF) and the data-access stage. Accesses are serialised through an
//   IDLE -> BUSY -> DONE FSM; completion is a one-cycle done pulse to the
//   owning requester. Data wins ties, but after MAX_D_BURST consecutive data
//   grants with fetch waiting, fetch is served. A watchdog aborts an access
//   that the memory does not acknowledge within TIMEOUT cycles (err=1).
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : mem_port_arbiter_if.slave (requesters, memory, status)
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_port_arbiter_if.slave        bus
);

    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant_d;
    logic          grant_if;
    logic          timeout_hit;

    logic          owner_r;
    logic [AW-1:0] addr_r;
    logic          we_r;
    logic [DW-1:0] wdata_r;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wdog;
    logic          err_r;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] d_rdata_r;

    // Burst counter increment that never passes the fetch-fairness limit.
    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
        return (v == BURST_MAX) ? v : v + BW'(1);
    endfunction

    assign timeout_hit = (wdog == WDOG_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decode; arbitration only happens in IDLE
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && burst_cnt == BURST_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY;
                end else if (bus.if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Access registers, fairness counter, watchdog and returned data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_r    <= 1'b0;
            addr_r     <= '0;
            we_r       <= 1'b0;
            wdata_r    <= '0;
            burst_cnt  <= '0;
            wdog       <= '0;
            err_r      <= 1'b0;
            if_rdata_r <= '0;
            d_rdata_r  <= '0;
        end else begin
            if (grant_d || grant_if) begin
                owner_r <= grant_d;
                addr_r  <= grant_d ? bus.d_addr : bus.if_addr;
                we_r    <= grant_d && bus.d_we;
                wdata_r <= grant_d ? bus.d_wdata : '0;
                wdog    <= '0;
                // Only consecutive data grants that actually held fetch off count.
                if (grant_d && bus.if_req) begin
                    burst_cnt <= sat_inc(burst_cnt);
                end else begin
                    burst_cnt <= '0;
                end
            end

            if (state == BUSY) begin
                if (bus.mem_ack) begin
                    // Ack beats a simultaneous watchdog expiry.
                    err_r <= 1'b0;
                    if (!owner_r) begin
                        if_rdata_r <= bus.mem_rdata;
                    end else if (!we_r) begin
                        d_rdata_r <= bus.mem_rdata;
                    end
                end else if (timeout_hit) begin
                    err_r <= 1'b1;
                    if (owner_r) begin
                        d_rdata_r <= '0;
                    end else begin
                        if_rdata_r <= '0;
                    end
                end else begin
                    wdog <= wdog + WW'(1);
                end
            end

            if (state == DONE) begin
                wdog <= '0;
            end
        end
    end

    assign bus.mem_req   = (state == BUSY);
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.if_done   = (state == DONE) && !owner_r;
    assign bus.d_done    = (state == DONE) && owner_r;
    assign bus.err       = (state == DONE) && err_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.owner     = owner_r;
    assign bus.busy      = (state != IDLE);

endmodule
